unified_mem_arbiter: RTL

Arbitrates one single-ported, synchronous-read unified memory between the instruction-fetch (IF) stage and the data-memory (MEM) stage of the pipelined RV32I core. It accepts at most one access per cycle and gives priority to data accesses. It produces byte enables for stores and returns aligned, sign/zero-extended load data one cycle after grant. It sits between the pipeline (driven by the control unit's MemRead/MemWrite) and the memory macro.

---
 rtl/arb_pkg.sv | 20 ++
 rtl/unified_mem_arbiter_load_align.sv | 29 ++
 rtl/unified_mem_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared owner encoding, RV32I load/store funct3 codes and misalignment helper for the memory arbiter.
package arb_pkg;

   typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DATA} owner_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b01:   return off[0];
         2'b10:   return off != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/unified_mem_arbiter_load_align.sv
// Load lane select and sign/zero extension; purely combinational, driven by the registered offset and funct3.
module load_align
   import arb_pkg::*;
(
   input  logic [2:0]  f3_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] word_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = 8'(word_i >> {off_i, 3'b000});
   assign half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

   always_comb begin
      data_o = 32'h0;
      case (f3_i)
         F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   data_o = {24'h0, byte_sel};
         F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
         F3_HU:   data_o = {16'h0, half_sel};
         F3_W:    data_o = word_i;
         default: data_o = 32'h0;
      endcase
   end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port memory arbiter, data over fetch; grant is combinational, read response one cycle later.
// Losers see stall_*; ARB_FAIRNESS_EN bounds fetch starvation to STARVE_MAX consecutive data grants.
module unified_mem_arbiter
   import arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int STARVE_MAX = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [31:0]       if_rdata,
   input  logic              d_re,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [2:0]        d_funct3,
   input  logic [31:0]       d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [31:0]       d_rdata,
   output logic              d_misalign,
   output logic              stall_if,
   output logic              stall_mem,
   output logic [ADDR_W-3:0] ram_addr,
   output logic              ram_re,
   output logic [3:0]        ram_we,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   owner_e     owner_q, owner_d;
   logic [2:0] f3_q;
   logic [1:0] off_q;
   logic       rd_q;
   logic       mis_q;
   logic       data_req;
   logic       force_if;
   logic       mis;
   logic [31:0] aligned;
   logic       unused_addr_lsb;

   assign data_req        = d_re | d_we;
   assign unused_addr_lsb = ^if_addr[1:0];

`ifdef ARB_FAIRNESS_EN
   localparam int CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
   logic [CW-1:0] starve_q;

   assign force_if = if_req & data_req & (starve_q == CW'(STARVE_MAX));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         starve_q <= '0;
      else if (if_gnt)
         starve_q <= '0;
      else if (d_gnt && if_req)
         starve_q <= starve_q + 1'b1;
   end
`else
   assign force_if = 1'b0;
`endif

   assign d_gnt      = data_req & ~force_if;
   assign if_gnt     = if_req & ~d_gnt;
   assign stall_if   = if_req & ~if_gnt;
   assign stall_mem  = data_req & ~d_gnt;
   assign mis        = d_gnt & is_misaligned(d_funct3, d_addr[1:0]);
   assign d_misalign = mis;
   assign ram_re     = if_gnt | (d_gnt & d_re);
   assign ram_addr   = d_gnt  ? d_addr[ADDR_W-1:2] :
                       if_gnt ? if_addr[ADDR_W-1:2] : '0;
   assign owner_d    = d_gnt ? OWN_DATA : (if_gnt ? OWN_IF : OWN_NONE);

   // Sub-word stores replicate data so the enabled lanes always see the right bytes.
   always_comb begin
      ram_we    = 4'b0000;
      ram_wdata = 32'h0;
      if (d_gnt && d_we && !mis) begin
         case (d_funct3[1:0])
            2'b00: begin
               ram_we    = 4'b0001 << d_addr[1:0];
               ram_wdata = {4{d_wdata[7:0]}};
            end
            2'b01: begin
               ram_we    = 4'b0011 << {d_addr[1], 1'b0};
               ram_wdata = {2{d_wdata[15:0]}};
            end
            default: begin
               ram_we    = 4'b1111;
               ram_wdata = d_wdata;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_q <= OWN_NONE;
         f3_q    <= 3'b000;
         off_q   <= 2'b00;
         rd_q    <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         owner_q <= owner_d;
         f3_q    <= d_funct3;
         off_q   <= d_addr[1:0];
         rd_q    <= d_gnt & d_re;
         mis_q   <= mis;
      end
   end

   load_align u_load_align (
      .f3_i   (f3_q),
      .off_i  (off_q),
      .word_i (ram_rdata),
      .data_o (aligned)
   );

   assign if_rvalid = (owner_q == OWN_IF);
   assign if_rdata  = if_rvalid ? ram_rdata : 32'h0;
   assign d_rvalid  = (owner_q == OWN_DATA) & rd_q;
   assign d_rdata   = (d_rvalid && !mis_q) ? aligned : 32'h0;

endmodule
